trap_ctrl: RTL
==============

Name: trap_ctrl

Overview:
- Core-local trap sequencer. It detects ECALL/EBREAK/MRET in the instruction at the ex stage and qualified external interrupt lines.
- It writes the machine trap CSRs (mepc, mcause, mstatus) over the CSR write port, one write per cycle.
- It redirects execution through ex using int_assert_o and int_addr_o.
- It raises hold_flag_o into the pipeline controller for the whole sequence. The controller maps that request to a full-pipeline hold.

Parameters:
- INT_NUM, 8, number of external interrupt lines (1..16).
- CAUSE_BASE, 16, mcause code of int_flag_i[0]; line k reports code CAUSE_BASE+k.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-low reset
- int_flag_i  in  INT_NUM  level interrupt requests
- inst_i  in  32  instruction currently in ex
- inst_addr_i  in  32  pc of inst_i
- jump_flag_i  in  1  ex is redirecting this cycle
- jump_addr_i  in  32  ex redirect target
- hold_flag_i  in  3  current pipeline hold from controller
- csr_mtvec_i  in  32  mtvec
- csr_mepc_i  in  32  mepc
- csr_mstatus_i  in  32  mstatus
- global_int_en_i  in  1  mstatus.MIE
- hold_flag_o  out  1  hold request to controller
- we_o  out  1  CSR write enable
- waddr_o  out  12  CSR write address
- data_o  out  32  CSR write data
- int_assert_o  out  1  redirect pulse to ex
- int_addr_o  out  32  redirect target

Behaviour:
- Reset (async, rst=0): state IDLE; we_o=0, waddr_o=0, data_o=0, int_assert_o=0, int_addr_o=0, hold_flag_o=0; latched cause and return address cleared. A reset asserted mid-sequence abandons the sequence and issues no further writes.
- Trigger classification in IDLE:
  - inst_i==0x00000073 (ECALL) → sync, cause 11.
  - inst_i==0x00100073 (EBREAK) → sync, cause 3.
  - inst_i==0x30200073 → MRET.
  - |int_flag_i & global_int_en_i & hold_flag_i==0 → async. Cause is 0x8000_0000|(CAUSE_BASE+k), where k is the lowest set bit.
  - Priority: sync > MRET > async.
- Return address latched at trigger:
  - sync: inst_addr_i+4.
  - async: jump_addr_i if jump_flag_i, else inst_addr_i.
- States: IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, ASSERT, MRET_MSTATUS, MRET_ASSERT. All states are registered.
- Trap path, cycle after trigger = T+1:
  - T+1 W_MEPC: we_o=1, waddr_o=0x341, data_o=return address.
  - T+2 W_MCAUSE: we_o=1, waddr_o=0x342, data_o=cause.
  - T+3 W_MSTATUS: we_o=1, waddr_o=0x300, data_o=mstatus with bit7 set to the old bit3 and bit3 cleared.
  - T+4 ASSERT: int_assert_o=1, int_addr_o=trap target. Then IDLE.
- MRET path:
  - T+1 MRET_MSTATUS: we_o=1, waddr_o=0x300, data_o=mstatus with bit3 set to bit7 and bit7 set to 1.
  - T+2 MRET_ASSERT: int_assert_o=1, int_addr_o=csr_mepc_i. Then IDLE.
- hold_flag_o is combinational: 1 on the trigger cycle and in every non-IDLE state, including the ASSERT cycles.
- we_o and int_assert_o are single-cycle pulses; never both high in one cycle.
- New triggers are ignored while not in IDLE. Interrupt lines are level-sensitive and are re-evaluated in IDLE after completion.
- A trigger arriving with jump_flag_i from a different instruction follows the same rules; only the async return address changes.

Optional Feature:
- Macro TRAP_CTRL_VECTORED_EN.
- Defined: when csr_mtvec_i[1:0]==1 and the trap is async, trap target = {mtvec[31:2],2'b00}+4*cause[30:0]. Sync traps always use the base.
- Undefined: trap target is always {mtvec[31:2],2'b00}; mtvec mode bits are ignored.

Decomposition:
- Shared defines header holds:
  - CSR addresses: CSR_MEPC 0x341, CSR_MCAUSE 0x342, CSR_MSTATUS 0x300.
  - Instruction encodings: INST_ECALL, INST_EBREAK, INST_MRET.
  - Hold/enable constants: HoldEnable, IntAssert.
- FSM state encodings stay local.
- One sub-module: trap_int_prio_enc. It is a parameterised lowest-set-bit encoder producing the index and a valid bit.

Test Plan:
- ECALL at inst_addr_i=0x100, mtvec=0x200, mstatus=0x8 → writes mepc=0x104, mcause=11, mstatus=0x80 on T+1..T+3; int_assert_o with int_addr_o=0x200 at T+4; hold_flag_o high T..T+4.
- int_flag_i=0b0100, MIE=1, hold_flag_i=0, inst_addr_i=0x300 → mcause=0x80000012, mepc=0x300. With jump_flag_i=1 and jump_addr_i=0x400 instead → mepc=0x400.
- MRET with mstatus=0x80, mepc=0x104 → mstatus write 0x88 at T+1; int_assert_o at T+2 with int_addr_o=0x104.
- ECALL and int_flag_i=1 in the same cycle → ECALL sequence only; interrupt taken immediately after return to IDLE if still pending and MIE=1.
- MIE=0 or hold_flag_i≠0 with int_flag_i=0xFF → no writes, hold_flag_o=0.
- rst low at T+2 of a trap → outputs 0 asynchronously; no int_assert_o after release. With TRAP_CTRL_VECTORED_EN, mtvec=0x201, cause 0x80000010 → int_addr_o=0x240.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// trap_ctrl_pkg
//
// Shared definitions for the core-local trap sequencer:
//   - machine CSR addresses written by the sequencer
//   - instruction encodings that start a trap or a trap return
//   - hold / redirect constants driven towards the pipeline
//   - trigger classification type and the two mstatus rewrite helpers
// -----------------------------------------------------------------------------
package trap_ctrl_pkg;

    // Machine trap CSR addresses
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;

    // System instruction encodings recognised in ex
    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    // Levels driven on the hold request and the redirect pulse
    localparam logic HoldEnable = 1'b1;
    localparam logic IntAssert  = 1'b1;

    // Synchronous exception cause codes
    localparam logic [31:0] CAUSE_ECALL  = 32'd11;
    localparam logic [31:0] CAUSE_EBREAK = 32'd3;

    // Async cause marker (mcause interrupt bit)
    localparam logic [31:0] CAUSE_INT_BIT = 32'h8000_0000;

    // Result of classifying the ex-stage instruction and interrupt lines
    typedef enum logic [1:0] {
        TRIG_NONE,
        TRIG_SYNC,
        TRIG_MRET,
        TRIG_ASYNC
    } trig_e;

    // Trap entry: MPIE (bit 7) takes the old MIE (bit 3), MIE is cleared.
    function automatic logic [31:0] mstatus_on_trap(input logic [31:0] m);
        logic [31:0] r;
        r    = m;
        r[7] = m[3];
        r[3] = 1'b0;
        return r;
    endfunction

    // Trap return: MIE is restored from MPIE, MPIE is set.
    function automatic logic [31:0] mstatus_on_mret(input logic [31:0] m);
        logic [31:0] r;
        r    = m;
        r[3] = m[7];
        r[7] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/trap_int_prio_enc.sv
// -----------------------------------------------------------------------------
// trap_int_prio_enc
//
// Lowest-set-bit encoder for the external interrupt lines. Line 0 has the
// highest priority.
//
// Ports:
//   req    in   WIDTH   request vector
//   idx    out  IDX_W   index of the lowest set bit (0 when none set)
//   valid  out  1       at least one request bit set
// -----------------------------------------------------------------------------
module trap_int_prio_enc #(
    parameter int WIDTH = 8,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan from the top down so the last hit (lowest index) wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
//
// Core-local trap sequencer. Detects ECALL / EBREAK / MRET in ex and qualified
// external interrupts, writes mepc, mcause and mstatus over the CSR write port
// (one write per cycle), then redirects ex to the trap target or back to mepc.
// The pipeline is held for the whole sequence.
//
// Build option:
//   TRAP_CTRL_VECTORED_EN  when defined, async traps with mtvec mode 1 jump to
//                          base + 4*cause[30:0]; otherwise the target is always
//                          the mtvec base.
//
// Ports:
//   clk              in   1        core clock
//   rst              in   1        asynchronous active-low reset
//   int_flag_i       in   INT_NUM  level interrupt requests
//   inst_i           in   32       instruction in ex
//   inst_addr_i      in   32       pc of inst_i
//   jump_flag_i      in   1        ex is redirecting this cycle
//   jump_addr_i      in   32       ex redirect target
//   hold_flag_i      in   3        current pipeline hold from controller
//   csr_mtvec_i      in   32       mtvec
//   csr_mepc_i       in   32       mepc
//   csr_mstatus_i    in   32       mstatus
//   global_int_en_i  in   1        mstatus.MIE
//   hold_flag_o      out  1        hold request to controller
//   we_o             out  1        CSR write enable
//   waddr_o          out  12       CSR write address
//   data_o           out  32       CSR write data
//   int_assert_o     out  1        redirect pulse to ex
//   int_addr_o       out  32       redirect target
//
// Interface timing: there is no back-pressure. we_o and int_assert_o are
// single-cycle pulses that the CSR file and ex must accept in the cycle they
// are high; they are never high together. hold_flag_o stays high from the
// trigger cycle through the redirect cycle.
// -----------------------------------------------------------------------------
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int INT_NUM    = 8,
    parameter int CAUSE_BASE = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INT_NUM-1:0] int_flag_i,
    input  logic [31:0]        inst_i,
    input  logic [31:0]        inst_addr_i,
    input  logic               jump_flag_i,
    input  logic [31:0]        jump_addr_i,
    input  logic [2:0]         hold_flag_i,
    input  logic [31:0]        csr_mtvec_i,
    input  logic [31:0]        csr_mepc_i,
    input  logic [31:0]        csr_mstatus_i,
    input  logic               global_int_en_i,
    output logic               hold_flag_o,
    output logic               we_o,
    output logic [11:0]        waddr_o,
    output logic [31:0]        data_o,
    output logic               int_assert_o,
    output logic [31:0]        int_addr_o
);

    localparam int IDX_W = (INT_NUM > 1) ? $clog2(INT_NUM) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_MEPC,
        S_W_MCAUSE,
        S_W_MSTATUS,
        S_ASSERT,
        S_MRET_MSTATUS,
        S_MRET_ASSERT
    } state_e;

    state_e state_q;
    state_e state_d;

    logic [31:0] cause_q;
    logic [31:0] ret_addr_q;

    // -------------------------------------------------------------------------
    // Interrupt line selection
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0] int_idx;
    logic             int_valid;

    trap_int_prio_enc #(
        .WIDTH (INT_NUM),
        .IDX_W (IDX_W)
    ) u_int_prio_enc (
        .req   (int_flag_i),
        .idx   (int_idx),
        .valid (int_valid)
    );

    // -------------------------------------------------------------------------
    // Trigger classification (only acted on in IDLE)
    // -------------------------------------------------------------------------
    trig_e       trig;
    logic [31:0] sync_cause;
    logic [31:0] async_cause;
    logic [31:0] async_ret;

    always_comb begin
        trig = TRIG_NONE;
        if (inst_i == INST_ECALL || inst_i == INST_EBREAK) begin
            trig = TRIG_SYNC;
        end else if (inst_i == INST_MRET) begin
            trig = TRIG_MRET;
        end else if (int_valid && global_int_en_i && (hold_flag_i == 3'b000)) begin
            // A pipeline already held by someone else must not be interrupted:
            // the instruction in ex may not be the one that will retire next.
            trig = TRIG_ASYNC;
        end
    end

    assign sync_cause  = (inst_i == INST_EBREAK) ? CAUSE_EBREAK : CAUSE_ECALL;
    assign async_cause = CAUSE_INT_BIT | (32'(CAUSE_BASE) + 32'(int_idx));
    // If ex is redirecting this cycle, the branch target is the next pc to run.
    assign async_ret   = jump_flag_i ? jump_addr_i : inst_addr_i;

    // -------------------------------------------------------------------------
    // Trap target
    // -------------------------------------------------------------------------
    logic [31:0] trap_base;
    logic [31:0] trap_target;

    assign trap_base = {csr_mtvec_i[31:2], 2'b00};

`ifdef TRAP_CTRL_VECTORED_EN
    // cause_q[31] marks an async trap; sync traps always land on the base.
    always_comb begin
        trap_target = trap_base;
        if (csr_mtvec_i[1:0] == 2'b01 && cause_q[31]) begin
            trap_target = trap_base + {cause_q[29:0], 2'b00};
        end
    end
`else
    // Mode bits are ignored in the non-vectored build.
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^csr_mtvec_i[1:0];
    assign trap_target       = trap_base;
`endif

    // -------------------------------------------------------------------------
    // State register and latched trap context
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cause_q    <= '0;
            ret_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE) begin
                if (trig == TRIG_SYNC) begin
                    cause_q    <= sync_cause;
                    ret_addr_q <= inst_addr_i + 32'd4;
                end else if (trig == TRIG_ASYNC) begin
                    cause_q    <= async_cause;
                    ret_addr_q <= async_ret;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next state and outputs. Outputs decode the registered state, so reset
    // clears them immediately and a reset mid-sequence leaves no pending write.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        hold_flag_o  = 1'b0;
        we_o         = 1'b0;
        waddr_o      = '0;
        data_o       = '0;
        int_assert_o = 1'b0;
        int_addr_o   = '0;

        case (state_q)
            S_IDLE: begin
                case (trig)
                    TRIG_SYNC, TRIG_ASYNC: begin
                        hold_flag_o = HoldEnable;
                        state_d     = S_W_MEPC;
                    end
                    TRIG_MRET: begin
                        hold_flag_o = HoldEnable;
                        state_d     = S_MRET_MSTATUS;
                    end
                    default: ;
                endcase
            end

            S_W_MEPC: begin
                hold_flag_o = HoldEnable;
                we_o        = 1'b1;
                waddr_o     = CSR_MEPC;
                data_o      = ret_addr_q;
                state_d     = S_W_MCAUSE;
            end

            S_W_MCAUSE: begin
                hold_flag_o = HoldEnable;
                we_o        = 1'b1;
                waddr_o     = CSR_MCAUSE;
                data_o      = cause_q;
                state_d     = S_W_MSTATUS;
            end

            S_W_MSTATUS: begin
                hold_flag_o = HoldEnable;
                we_o        = 1'b1;
                waddr_o     = CSR_MSTATUS;
                data_o      = mstatus_on_trap(csr_mstatus_i);
                state_d     = S_ASSERT;
            end

            S_ASSERT: begin
                hold_flag_o  = HoldEnable;
                int_assert_o = IntAssert;
                int_addr_o   = trap_target;
                state_d      = S_IDLE;
            end

            S_MRET_MSTATUS: begin
                hold_flag_o = HoldEnable;
                we_o        = 1'b1;
                waddr_o     = CSR_MSTATUS;
                data_o      = mstatus_on_mret(csr_mstatus_i);
                state_d     = S_MRET_ASSERT;
            end

            S_MRET_ASSERT: begin
                hold_flag_o  = HoldEnable;
                int_assert_o = IntAssert;
                int_addr_o   = csr_mepc_i;
                state_d      = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
